cache_req_sequencer: RTL

- Sits directly upstream of the set-associative cache: accepts byte read/write requests from the core over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one request per cycle to the cache.
- Pairs each request with the cache's registered hit/miss/rd_data one cycle later and returns a tagged response pulse.
- Keeps hit/miss statistics for performance experiments.

---
 rtl/cache_req_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cache_req_sequencer.sv
// Request FIFO and two-stage issue/compare pipeline in front of the set-associative cache.
// Optional hit/miss statistics are enabled with `define CACHE_SEQ_STATS_EN.
module cache_req_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_addr,
   input  logic                 req_wr,
   input  logic [7:0]           req_wdata,
   output logic [31:0]          cache_addr,
   output logic                 cache_wr_en,
   output logic [7:0]           cache_wr_data,
   input  logic                 cache_hit,
   input  logic                 cache_miss,
   input  logic [7:0]           cache_rd_data,
   output logic                 resp_valid,
   output logic                 resp_wr,
   output logic                 resp_hit,
   output logic [7:0]           resp_rdata,
   output logic                 busy,
   input  logic                 clear_stats,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [31:0] fifo_addr  [FIFO_DEPTH];
   logic        fifo_wr    [FIFO_DEPTH];
   logic [7:0]  fifo_wdata [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic push;
   logic pop;
   logic s0_valid;
   logic s1_valid;
   logic s1_wr;

   assign req_ready = (count < (PW+1)'(FIFO_DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (count != '0);
   assign busy      = pop || s0_valid || s1_valid;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr]  <= req_addr;
         fifo_wr[wr_ptr]    <= req_wr;
         fifo_wdata[wr_ptr] <= req_wdata;
      end
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue stage: when idle, cache_addr holds so the cache just re-reads the last line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_valid      <= 1'b0;
         cache_addr    <= '0;
         cache_wr_en   <= 1'b0;
         cache_wr_data <= '0;
      end else if (pop) begin
         s0_valid      <= 1'b1;
         cache_addr    <= fifo_addr[rd_ptr];
         cache_wr_en   <= fifo_wr[rd_ptr];
         cache_wr_data <= fifo_wdata[rd_ptr];
      end else begin
         s0_valid    <= 1'b0;
         cache_wr_en <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_wr      <= 1'b0;
         resp_valid <= 1'b0;
         resp_wr    <= 1'b0;
         resp_hit   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         s1_valid   <= s0_valid;
         s1_wr      <= cache_wr_en;
         resp_valid <= s1_valid;
         resp_wr    <= s1_wr;
         resp_hit   <= cache_hit;
         resp_rdata <= (!s1_wr && cache_hit) ? cache_rd_data : '0;
      end
   end

`ifdef CACHE_SEQ_STATS_EN
   logic hit_inc;
   logic miss_inc;

   // An inconsistent cache report (hit == miss) counts as neither.
   assign hit_inc  = s1_valid && cache_hit && !cache_miss;
   assign miss_inc = s1_valid && cache_miss && !cache_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (clear_stats) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + CNT_WIDTH'(1);
         if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_WIDTH'(1);
      end
   end
`else
   logic unused_stats;

   assign unused_stats = ^{clear_stats, cache_miss};
   assign hit_count    = '0;
   assign miss_count   = '0;
`endif

endmodule
